// File: rtl/i2s_rx_fifo.sv
// I2S receiver: pin synchroniser, stereo deserializer and frame FIFO.
// Optional BIST pattern source is built when I2SI_BIST_EN is defined.
module i2s_rx_fifo #(
  parameter int unsigned WORD_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i2si_sck,
  input  logic                          i2si_ws,
  input  logic                          i2si_sd,
  input  logic                          rf_i2si_en,
  input  logic                          rf_i2si_bist_en,
  input  logic [WORD_W-1:0]             rf_bist_start_val,
  input  logic [7:0]                    rf_bist_inc,
  input  logic [WORD_W-1:0]             rf_bist_up_limit,
  input  logic                          trig_fifo_overrun_clr,
  input  logic                          i2si_rtr,
  output logic [2*WORD_W-1:0]           i2si_data,
  output logic                          i2si_rts,
  output logic                          ro_fifo_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   ro_fifo_level,
  output logic                          i2si_sync_sck,
  output logic                          i2si_sync_sck_transition
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = $clog2(WORD_W + 1);
  localparam int unsigned FrmW  = 2 * WORD_W;
  localparam logic [WORD_W-1:0] TopBit = {1'b1, {(WORD_W - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StWaitL, StLeft, StRight} state_e;

  logic sck_meta, sck_sync, sck_hist, ws_meta, ws_sync, sd_meta, sd_sync;
  logic sck_rise;

  // Two-flop synchronisers on every pin plus an sck history flop for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {sck_meta, sck_sync, sck_hist} <= '0;
      {ws_meta, ws_sync, sd_meta, sd_sync} <= '0;
    end else begin
      sck_meta <= i2si_sck;
      sck_sync <= sck_meta;
      sck_hist <= sck_sync;
      ws_meta  <= i2si_ws;
      ws_sync  <= ws_meta;
      sd_meta  <= i2si_sd;
      sd_sync  <= sd_meta;
    end
  end

  assign sck_rise                 = sck_sync & ~sck_hist;
  assign i2si_sync_sck            = sck_sync;
  assign i2si_sync_sck_transition = sck_sync ^ sck_hist;

  state_e              state_q, state_d;
  logic                ws_prev_q, ws_prev_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d, left_q, left_d, word_in;
  logic [CntW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic                frame_strobe, deser_en, bist_sel;
  logic                push_req, fifo_full, do_push, do_pop, ovr_set;
  logic [FrmW-1:0]     push_data;

  // Bits land MSB-first at a moving mask; the mask shifts out to zero once WORD_W
  // bits are held, so overlong words are truncated and short ones left-justified.
  assign word_in  = shreg_q | ({WORD_W{sd_sync}} & (TopBit >> cnt_q));
  assign cnt_inc  = (cnt_q == CntW'(WORD_W)) ? cnt_q : cnt_q + CntW'(1);
  assign deser_en = rf_i2si_en & ~bist_sel;

  // Deserializer state, shift register and held left word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ws_prev_q <= 1'b0;
      shreg_q   <= '0;
      cnt_q     <= '0;
      left_q    <= '0;
    end else begin
      state_q   <= state_d;
      ws_prev_q <= ws_prev_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      left_q    <= left_d;
    end
  end

  // Deserializer next state; a ws change marks the LSB of the channel just ending.
  always_comb begin
    state_d      = state_q;
    ws_prev_d    = ws_prev_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    left_d       = left_q;
    frame_strobe = 1'b0;
    if (sck_rise) ws_prev_d = ws_sync;
    if (!deser_en) begin
      state_d = StIdle;
      shreg_d = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StWaitL;
        StWaitL: begin
          if (sck_rise && ws_prev_q && !ws_sync) begin
            state_d = StLeft;
            shreg_d = '0;
            cnt_d   = '0;
          end
        end
        StLeft, StRight: begin
          if (sck_rise) begin
            shreg_d = word_in;
            cnt_d   = cnt_inc;
            if (ws_sync != ws_prev_q) begin
              shreg_d = '0;
              cnt_d   = '0;
              if (state_q == StLeft) begin
                left_d  = word_in;
                state_d = StRight;
              end else begin
                frame_strobe = 1'b1;
                state_d      = StLeft;
              end
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

`ifdef I2SI_BIST_EN
  logic [WORD_W-1:0] bist_cnt_q, bist_cnt_d;
  logic [WORD_W:0]   bist_next;
  logic              bist_wr;

  assign bist_sel  = rf_i2si_bist_en;
  assign bist_wr   = rf_i2si_bist_en & ~fifo_full;
  assign bist_next = {1'b0, bist_cnt_q} + (WORD_W + 1)'(rf_bist_inc);
  assign push_req  = bist_sel ? bist_wr : frame_strobe;
  assign push_data = bist_sel ? {bist_cnt_q, bist_cnt_q} : {left_q, word_in};

  // BIST counter: parked at the start value while disabled, wraps past the limit.
  always_comb begin
    bist_cnt_d = bist_cnt_q;
    if (!rf_i2si_bist_en) begin
      bist_cnt_d = rf_bist_start_val;
    end else if (bist_wr) begin
      bist_cnt_d = (bist_next > {1'b0, rf_bist_up_limit}) ? rf_bist_start_val
                                                          : bist_next[WORD_W-1:0];
    end
  end

  // BIST counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) bist_cnt_q <= '0;
    else        bist_cnt_q <= bist_cnt_d;
  end
`else
  logic unused_bist;
  assign unused_bist = ^{rf_i2si_bist_en, rf_bist_start_val, rf_bist_inc, rf_bist_up_limit};
  assign bist_sel    = 1'b0;
  assign push_req    = frame_strobe;
  assign push_data   = {left_q, word_in};
`endif

  logic [FrmW-1:0]  mem_q [FIFO_DEPTH];
  logic [AddrW-1:0] wptr_q, rptr_q;
  logic [AddrW:0]   level_q;
  logic             overrun_q;

  assign fifo_full = (level_q == (AddrW + 1)'(FIFO_DEPTH));
  assign do_pop    = i2si_rts & i2si_rtr;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push   = push_req & (~fifo_full | do_pop);
  assign ovr_set   = push_req & fifo_full & ~do_pop;

  // FIFO storage, deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data;
  end

  // FIFO pointers, occupancy and sticky overrun (set beats clear).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AddrW'(1);
      if (do_pop)  rptr_q <= rptr_q + AddrW'(1);
      if (do_push && !do_pop)      level_q <= level_q + (AddrW + 1)'(1);
      else if (!do_push && do_pop) level_q <= level_q - (AddrW + 1)'(1);
      if (ovr_set)                    overrun_q <= 1'b1;
      else if (trig_fifo_overrun_clr) overrun_q <= 1'b0;
    end
  end

  assign i2si_rts        = (level_q != '0);
  assign i2si_data       = i2si_rts ? mem_q[rptr_q] : '0;
  assign ro_fifo_level   = level_q;
  assign ro_fifo_overrun = overrun_q;

endmodule

// File: tb/tb_i2s_rx_fifo.sv
// Self-checking bench for i2s_rx_fifo; the BIST section needs I2SI_BIST_EN.
module tb_i2s_rx_fifo;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int LW = $clog2(D) + 1;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          sck = 1'b0, ws = 1'b0, sd = 1'b0;
  logic          en = 1'b0, bist_en = 1'b0, clr = 1'b0, rtr = 1'b0;
  logic [W-1:0]  start_val = '0, limit = '0;
  logic [7:0]    inc = '0;
  logic [2*W-1:0] data;
  logic          rts, ovr, sync_sck, sck_tr;
  logic [LW-1:0] level;

  int             n_vec = 0, n_err = 0;
  logic [2*W-1:0] exp_q[$];
  bit             mon_en = 1'b1;

  i2s_rx_fifo #(.WORD_W(W), .FIFO_DEPTH(D)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .i2si_sck                 (sck),
    .i2si_ws                  (ws),
    .i2si_sd                  (sd),
    .rf_i2si_en               (en),
    .rf_i2si_bist_en          (bist_en),
    .rf_bist_start_val        (start_val),
    .rf_bist_inc              (inc),
    .rf_bist_up_limit         (limit),
    .trig_fifo_overrun_clr    (clr),
    .i2si_rtr                 (rtr),
    .i2si_data                (data),
    .i2si_rts                 (rts),
    .ro_fifo_overrun          (ovr),
    .ro_fifo_level            (level),
    .i2si_sync_sck            (sync_sck),
    .i2si_sync_sck_transition (sck_tr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted pop is checked against the oldest expected frame.
  always @(negedge clk) begin
    if (mon_en && rst_n && rts && rtr) begin
      if (exp_q.size() == 0) check_eq("sb_unexpected_pop", 64'(exp_q.size() != 0), 64'd1);
      else                   check_eq("sb_pop_data", 64'(data), 64'(exp_q.pop_front()));
    end
  end

  function automatic logic [W-1:0] just(input logic [31:0] v, input int n);
    if (n >= W) return W'(v >> (n - W));
    else        return W'(v << (W - n));
  endfunction

  // mode 0: plain bit; 1: pulse rtr in the frame-strobe cycle; 2: check push latency.
  task automatic send_bit(input logic b, input logic w, input int mode);
    bit seen;
    sck = 1'b0; sd = b; ws = w;
    repeat (4) @(posedge clk);
    #1 sck = 1'b1;
    if (mode != 0) begin
      seen = 1'b0;
      for (int i = 0; i < 6 && !seen; i++) begin
        @(posedge clk); #1;
        if (sync_sck) begin
          seen = 1'b1;
          check_eq("sck_sync_latency", 64'(i), 64'd1);
          check_eq("sck_transition", 64'(sck_tr), 64'd1);
          if (mode == 1) begin
            rtr = 1'b1;
            @(posedge clk); #1 rtr = 1'b0;
          end else begin
            check_eq("rts_before_push", 64'(rts), 64'd0);
            @(posedge clk); #1;
            check_eq("rts_after_push", 64'(rts), 64'd1);
            check_eq("level_after_push", 64'(level), 64'd1);
          end
        end
      end
      if (!seen) check_eq("sck_sync_timeout", 64'(seen), 64'd1);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] v, input int n, input logic wsv, input int mode);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i], (i == 0) ? ~wsv : wsv, (i == 0) ? mode : 0);
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n,
                            input int mode, input bit expect_push);
    if (expect_push) exp_q.push_back({just(l, n), just(r, n)});
    send_word(l, n, 1'b0, 0);
    send_word(r, n, 1'b1, mode);
  endtask

  // Tail of a dummy right word, ending in the ws 1->0 sample that opens a left word.
  task automatic preamble();
    send_bit(1'b1, 1'b1, 0);
    send_bit(1'b1, 1'b1, 0);
    send_bit(1'b0, 1'b0, 0);
  endtask

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 50 && rts; i++) begin
      @(posedge clk); #1;
    end
    check_eq(tag, 64'(rts), 64'd0);
    check_eq({tag, "_data"}, 64'(data), 64'd0);
  endtask

  task automatic check_idle(input string pfx);
    check_eq({pfx, "_data"}, 64'(data), 64'd0);
    check_eq({pfx, "_rts"}, 64'(rts), 64'd0);
    check_eq({pfx, "_ovr"}, 64'(ovr), 64'd0);
    check_eq({pfx, "_level"}, 64'(level), 64'd0);
    check_eq({pfx, "_sync_sck"}, 64'(sync_sck), 64'd0);
    check_eq({pfx, "_sck_tr"}, 64'(sck_tr), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 check_idle("reset");
    rst_n = 1'b1; en = 1'b1;
    @(posedge clk); #1;

    // Basic 16-bit frame, held at the head until rtr rises.
    preamble();
    send_frame(32'hA5C3, 32'h1234, 16, 2, 1'b1);
    check_eq("t1_data", 64'(data), 64'hA5C31234);
    rtr = 1'b1;
    wait_empty("t1_drain");

    // Overlong and short words.
    send_frame(32'h3FFFF, 32'h00001, 18, 0, 1'b1);
    send_frame(32'hABC, 32'h123, 12, 0, 1'b1);
    wait_empty("t2_drain");

    // Overrun with rtr low, clear, then full push+pop in one cycle.
    rtr = 1'b0;
    for (int i = 0; i < 5; i++) send_frame(32'h1000 + i, 32'h2000 + i, 16, 0, i < 4);
    check_eq("t3_level_full", 64'(level), 64'd4);
    check_eq("t3_overrun_set", 64'(ovr), 64'd1);
    clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    check_eq("t3_overrun_clr", 64'(ovr), 64'd0);
    send_frame(32'h5555, 32'hAAAA, 16, 1, 1'b1);
    check_eq("t3_pushpop_ovr", 64'(ovr), 64'd0);
    check_eq("t3_pushpop_level", 64'(level), 64'd4);
    rtr = 1'b1;
    wait_empty("t3_drain");

    // Disable mid-right word, then re-enable.
    send_word(32'h7777, 16, 1'b0, 0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1, 0);
    en = 1'b0;
    repeat (10) @(posedge clk);
    #1 en = 1'b1;
    preamble();
    send_frame(32'h1357, 32'h2468, 16, 0, 1'b1);
    wait_empty("t4_drain");
    check_eq("t4_sb_empty", 64'(exp_q.size()), 64'd0);

    // Reset mid-frame with three frames buffered.
    rtr = 1'b0;
    for (int i = 0; i < 3; i++) send_frame(32'h0F00 + i, 32'h00F0 + i, 16, 0, 1'b1);
    check_eq("t5_level3", 64'(level), 64'd3);
    send_word(32'h4444, 16, 1'b0, 0);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b1, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_idle("t5_rst");
    exp_q.delete();
    rst_n = 1'b1; rtr = 1'b1;
    preamble();
    send_frame(32'hBEEF, 32'hCAFE, 16, 0, 1'b1);
    wait_empty("t5_drain");

`ifdef I2SI_BIST_EN
    begin
      logic [W-1:0] m;
      logic [W:0]   nxt;
      int           got;
      mon_en = 1'b0;
      start_val = 16'h0010; inc = 8'h08; limit = 16'h0020;
      repeat (2) @(posedge clk);
      #1 bist_en = 1'b1;
      m = 16'h0010; got = 0;
      for (int k = 0; k < 40 && got < 8; k++) begin
        @(negedge clk);
        if (rts && rtr) begin
          check_eq("bist_data", 64'(data), 64'({m, m}));
          nxt = {1'b0, m} + 17'(inc);
          m   = (nxt > {1'b0, limit}) ? start_val : nxt[W-1:0];
          got++;
        end
      end
      check_eq("bist_count", 64'(got), 64'd8);
      check_eq("bist_no_ovr", 64'(ovr), 64'd0);
      @(posedge clk); #1 bist_en = 1'b0;
      wait_empty("bist_drain");
      mon_en = 1'b1;
    end
`endif

    check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
